// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller.
//   Merges hold requests (CLINT, EX, fetch bus) into a per-stage stall vector,
//   sequences branch/jump redirects (zero-latency PC load plus a multi-cycle
//   IF/ID flush) and counts stalled cycles in a saturating counter.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   jump_req_i/addr_i   redirect request from EX and its target
//   stall_ex_i          EX busy with a multi-cycle op
//   stall_bus_i         fetch bus not ready
//   inst_valid_i        fetched instruction valid
//   hold_clint_i        CLINT holds the whole pipe
//   cnt_clr_i           clear stall counter
//   stall_o             {EX, ID, IF, PC} hold bits
//   flush_o             flush IF/ID register
//   jump_flag_o/addr_o  PC load strobe and value
//   stall_cnt_o         cycles with any stall bit set (saturating)
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             jump_req_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             stall_ex_i,
  input  logic             stall_bus_i,
  input  logic             inst_valid_i,
  input  logic             hold_clint_i,
  input  logic             cnt_clr_i,
  output logic [3:0]       stall_o,
  output logic             flush_o,
  output logic             jump_flag_o,
  output logic [31:0]      jump_addr_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              acc, flush, fetch_stall;
  logic [3:0]        stall;

  // A redirect is only taken when the pipe is free to move; EX re-issues
  // any request dropped under a CLINT hold.
  assign acc = jump_req_i & ~hold_clint_i;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    flush   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (acc) begin
          flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
          end
        end
      end
      FLUSH: begin
        if (acc) begin
          // Newer redirect wins: restart the flush window.
          flush  = 1'b1;
          fcnt_d = FC_W'(FLUSH_CYCLES - 1);
        end else if (!hold_clint_i) begin
          // Under a CLINT hold nothing moves, so the window is frozen.
          flush  = 1'b1;
          fcnt_d = fcnt_q - FC_W'(1);
          if (fcnt_q == FC_W'(1)) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Fetch stalls are irrelevant while flushing: the stale fetch is dropped.
  assign fetch_stall = (stall_bus_i | ~inst_valid_i) & (state_q != FLUSH);

  always_comb begin
    stall = 4'b0000;
    if (hold_clint_i)     stall = 4'b1111;
    else if (stall_ex_i)  stall = 4'b0111;
    else if (fetch_stall) stall = 4'b0011;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i)                          cnt_d = '0;
    else if (stall != 4'b0000 && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs are forced low while reset is asserted.
  assign stall_o     = rst_n ? stall : 4'b0000;
  assign flush_o     = rst_n & flush;
  assign jump_flag_o = rst_n & acc;
  assign jump_addr_o = (rst_n & acc) ? jump_addr_i : 32'h0;
  assign stall_cnt_o = rst_n ? cnt_q : '0;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios plus random traffic. A driver
// computes expected outputs from a behavioural model and queues them; a
// monitor on the falling edge pops and compares.
module tb_pipe_ctrl;
  localparam int FC    = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             jump_req_i = 1'b0;
  logic [31:0]      jump_addr_i = '0;
  logic             stall_ex_i = 1'b0, stall_bus_i = 1'b0, inst_valid_i = 1'b1;
  logic             hold_clint_i = 1'b0, cnt_clr_i = 1'b0;
  logic [3:0]       stall_o;
  logic             flush_o, jump_flag_o;
  logic [31:0]      jump_addr_o;
  logic [CNT_W-1:0] stall_cnt_o;

  pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
    .stall_ex_i(stall_ex_i), .stall_bus_i(stall_bus_i), .inst_valid_i(inst_valid_i),
    .hold_clint_i(hold_clint_i), .cnt_clr_i(cnt_clr_i), .stall_o(stall_o),
    .flush_o(flush_o), .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  stall;
    logic        flush;
    logic        jf;
    logic [31:0] ja;
    int          cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0, cyc = 0;

  // Behavioural model: remaining owed flush cycles and a plain integer count.
  int m_rem = 0, m_cnt = 0;

  task automatic chk(string nm, int c, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall_o",     e.cyc, {28'h0, stall_o},     {28'h0, e.stall});
      chk("flush_o",     e.cyc, {31'h0, flush_o},     {31'h0, e.flush});
      chk("jump_flag_o", e.cyc, {31'h0, jump_flag_o}, {31'h0, e.jf});
      chk("jump_addr_o", e.cyc, jump_addr_o,          e.ja);
      chk("stall_cnt_o", e.cyc, {28'h0, stall_cnt_o}, 32'(e.cnt));
    end
  end

  // Apply inputs for one cycle, queue the expected response, advance model.
  task automatic drive(bit rst, bit j, logic [31:0] a, bit ex, bit bus, bit iv,
                       bit hold, bit clr);
    exp_t e;
    bit   acc, in_flush;
    rst_n = ~rst; jump_req_i = j; jump_addr_i = a; stall_ex_i = ex;
    stall_bus_i = bus; inst_valid_i = iv; hold_clint_i = hold; cnt_clr_i = clr;
    e.cyc = cyc; e.stall = 4'h0; e.flush = 0; e.jf = 0; e.ja = 0; e.cnt = 0;
    if (rst) begin
      m_rem = 0; m_cnt = 0;
    end else begin
      acc      = j && !hold;
      in_flush = m_rem > 0;
      e.cnt    = m_cnt;
      e.jf     = acc;
      e.ja     = acc ? a : 32'h0;
      if (hold)                          e.stall = 4'b1111;
      else if (ex)                       e.stall = 4'b0111;
      else if (!in_flush && (bus || !iv)) e.stall = 4'b0011;
      if (acc) begin
        e.flush = 1; m_rem = FC - 1;
      end else if (m_rem > 0 && !hold) begin
        e.flush = 1; m_rem--;
      end
      if (clr)                  m_cnt = 0;
      else if (e.stall != 4'h0) m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
    end
    q.push_back(e);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    @(posedge clk); #1;
    // T1: reset with jump pending, outputs all zero
    repeat (3) drive(1, 1, 32'h1234, 1, 1, 0, 1, 0);
    idle(2);
    // T2: single jump, two-cycle flush
    drive(0, 1, 32'h100, 0, 0, 1, 0, 0);
    idle(3);
    // T3: clint hold beats EX stall and jump
    drive(0, 1, 32'h300, 1, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 0, 1, 0, 0);
    idle(2);
    // T4: re-accept inside flush window
    drive(0, 1, 32'h100, 0, 0, 1, 0, 0);
    drive(0, 1, 32'h200, 0, 0, 1, 0, 0);
    idle(3);
    // T5: clint hold in mid-flush freezes the window
    drive(0, 1, 32'h400, 0, 0, 1, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 1, 1, 0);
    idle(3);
    // jump with EX stall, plus bus stall masked during flush
    drive(0, 1, 32'h500, 1, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    // T6: counter saturation then clear while stalled
    drive(0, 0, 0, 0, 0, 1, 0, 1);
    repeat (20) drive(0, 0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 0, 1);
    idle(2);
    // reset mid-flush
    drive(0, 1, 32'h600, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    idle(3);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(99) < 3, $urandom_range(99) < 25, $urandom,
            $urandom_range(99) < 20, $urandom_range(99) < 25,
            $urandom_range(99) < 85, $urandom_range(99) < 10,
            $urandom_range(99) < 4);
    end
    idle(1);
    // bounded drain of the scoreboard
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
